// File: rtl/alu_reg_file.sv
// alu_reg_file: 8 x 8-bit register file (2 comb read ports, 1 write port) feeding an 8-bit ALU.
// Latency: reads and ALU are combinational; register write lands 1 CLK edge later.
// Backpressure: none; every edge with WRITEENABLE=1 commits ALU_RESULT. Optional macro ALU_REG_FILE_SIM_DELAY_EN adds sim delays.
`ifdef ALU_REG_FILE_SIM_DELAY_EN
    `define ALU_REG_FILE_WDLY #1
`else
    `define ALU_REG_FILE_WDLY
`endif

module alu_reg_file (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       WRITEENABLE,
    input  logic [2:0] WRITEREG,
    input  logic [2:0] READREG1,
    input  logic [2:0] READREG2,
    input  logic [7:0] OPERAND2,
    input  logic [2:0] ALUOP,
    output logic [7:0] REGOUT1,
    output logic [7:0] REGOUT2,
    output logic [7:0] ALU_RESULT,
    output logic       ZERO
);

    localparam int         NREGS  = 8;
    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    logic [7:0] regs [NREGS];
    logic [7:0] alu_val;

    // Register state: reset clears everything and wins over a same-edge write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= `ALU_REG_FILE_WDLY 8'h00;
            end
        end else if (WRITEENABLE) begin
            regs[WRITEREG] <= `ALU_REG_FILE_WDLY ALU_RESULT;
        end
    end

    // ALU: operand 1 is always read port 1; reserved ops force zero.
    always_comb begin
        alu_val = 8'h00;
        case (ALUOP)
            OP_FWD:  alu_val = OPERAND2;
            OP_ADD:  alu_val = REGOUT1 + OPERAND2;
            OP_AND:  alu_val = REGOUT1 & OPERAND2;
            OP_OR:   alu_val = REGOUT1 | OPERAND2;
            default: alu_val = 8'h00;
        endcase
    end

`ifdef ALU_REG_FILE_SIM_DELAY_EN
    logic [7:0] alu_fast;
    logic [7:0] alu_slow;

    // Reads see no write bypass; the old value is visible until the edge.
    assign #2 REGOUT1 = regs[READREG1];
    assign #2 REGOUT2 = regs[READREG2];

    // ADD is modelled slower than the bitwise and forwarding paths.
    assign #1 alu_fast  = alu_val;
    assign #2 alu_slow  = alu_val;
    assign ALU_RESULT   = (ALUOP == OP_ADD) ? alu_slow : alu_fast;
`else
    // Reads see no write bypass; the old value is visible until the edge.
    assign REGOUT1    = regs[READREG1];
    assign REGOUT2    = regs[READREG2];
    assign ALU_RESULT = alu_val;
`endif

    // Branch flag tracks the ALU result in every mode.
    assign ZERO = (ALU_RESULT == 8'h00);

endmodule

`undef ALU_REG_FILE_WDLY

// File: tb/tb_alu_reg_file.sv
// Testbench for alu_reg_file: directed table, hand-written corner sequences, random vs. model.
// Inputs change 1 unit after each rising edge; outputs are sampled 1 unit later.
// Reference model is a plain array plus an arithmetic ALU function.
module tb_alu_reg_file;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITEENABLE;
    logic [2:0] WRITEREG;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic [7:0] OPERAND2;
    logic [2:0] ALUOP;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALU_RESULT;
    logic       ZERO;

    int tests_run = 0;
    int failed    = 0;

    logic [7:0] model [8];

    alu_reg_file dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WRITEENABLE(WRITEENABLE),
        .WRITEREG   (WRITEREG),
        .READREG1   (READREG1),
        .READREG2   (READREG2),
        .OPERAND2   (OPERAND2),
        .ALUOP      (ALUOP),
        .REGOUT1    (REGOUT1),
        .REGOUT2    (REGOUT2),
        .ALU_RESULT (ALU_RESULT),
        .ZERO       (ZERO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] op;
        logic       we;
        logic [2:0] wreg;
        logic [2:0] rd1;
        logic [2:0] rd2;
        logic [7:0] op2;
        logic [7:0] exp_res;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int s;
        case (op)
            3'd0:    return b;
            3'd1:    begin s = (int'(a) + int'(b)) % 256; return s[7:0]; end
            3'd2:    return a & b;
            3'd3:    return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Advance one edge, updating the model from the inputs present before it.
    task automatic step();
        logic [7:0] wval;
        wval = ref_alu(ALUOP, model[READREG1], OPERAND2);
        @(posedge CLK);
        if (RESET) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (WRITEENABLE) begin
            model[WRITEREG] = wval;
        end
        #1;
    endtask

    task automatic check_vs_model(input string tag);
        logic [7:0] r;
        #1;
        r = ref_alu(ALUOP, model[READREG1], OPERAND2);
        check8({tag, " regout1"}, REGOUT1, model[READREG1]);
        check8({tag, " regout2"}, REGOUT2, model[READREG2]);
        check8({tag, " alu"}, ALU_RESULT, r);
        check1({tag, " zero"}, ZERO, r == 8'h00);
    endtask

    task automatic check_all_regs(input string tag, input logic [7:0] exp_all, input logic use_model);
        for (int i = 0; i < 8; i++) begin
            READREG1 = 3'(i);
            #1;
            check8($sformatf("%s R%0d", tag, i), REGOUT1, use_model ? model[i] : exp_all);
        end
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b1, 3'd5, 3'd5, 3'd0, 8'h2C, 8'h2C, 1'b0};
        vecs[1] = '{3'b000, 1'b1, 3'd1, 3'd1, 3'd5, 8'hF0, 8'hF0, 1'b0};
        vecs[2] = '{3'b001, 1'b1, 3'd1, 3'd1, 3'd1, 8'h10, 8'h00, 1'b1};
        vecs[3] = '{3'b000, 1'b1, 3'd2, 3'd2, 3'd1, 8'hCC, 8'hCC, 1'b0};
        vecs[4] = '{3'b010, 1'b0, 3'd2, 3'd2, 3'd2, 8'hAA, 8'h88, 1'b0};
        vecs[5] = '{3'b011, 1'b0, 3'd2, 3'd2, 3'd5, 8'hAA, 8'hEE, 1'b0};
        vecs[6] = '{3'b110, 1'b0, 3'd2, 3'd2, 3'd2, 8'hAA, 8'h00, 1'b1};
        vecs[7] = '{3'b111, 1'b1, 3'd2, 3'd2, 3'd3, 8'hFF, 8'h00, 1'b1};
        vecs[8] = '{3'b001, 1'b1, 3'd3, 3'd5, 3'd2, 8'h01, 8'h2D, 1'b0};
        vecs[9] = '{3'b010, 1'b1, 3'd3, 3'd3, 3'd5, 8'h0F, 8'h0D, 1'b0};

        RESET = 1'b1; WRITEENABLE = 1'b0; WRITEREG = 3'd0;
        READREG1 = 3'd0; READREG2 = 3'd0; OPERAND2 = 8'h00; ALUOP = 3'b000;
        @(negedge CLK);
        step();
        RESET = 1'b0;
        check_all_regs("reset", 8'h00, 1'b0);

        // Reset overrides a same-edge write.
        ALUOP = 3'b000; OPERAND2 = 8'hA5; WRITEREG = 3'd3; WRITEENABLE = 1'b1; READREG1 = 3'd3;
        step();
        check8("write A5 to R3", REGOUT1, 8'hA5);
        RESET = 1'b1; OPERAND2 = 8'h5A;
        step();
        RESET = 1'b0; WRITEENABLE = 1'b0;
        check_all_regs("reset over write", 8'h00, 1'b0);

        // Directed table; model must agree with the hand-computed expectations.
        for (int v = 0; v < 10; v++) begin
            ALUOP = vecs[v].op; WRITEENABLE = vecs[v].we; WRITEREG = vecs[v].wreg;
            READREG1 = vecs[v].rd1; READREG2 = vecs[v].rd2; OPERAND2 = vecs[v].op2;
            #1;
            check8($sformatf("vec%0d alu", v), ALU_RESULT, vecs[v].exp_res);
            check1($sformatf("vec%0d zero", v), ZERO, vecs[v].exp_zero);
            step();
            check8($sformatf("vec%0d regout1 post", v), REGOUT1, model[vecs[v].rd1]);
        end
        READREG1 = 3'd1; #1;
        check8("R1 wrapped to 00", REGOUT1, 8'h00);
        READREG1 = 3'd3; #1;
        check8("R3 final", REGOUT1, 8'h0D);

        // Read-during-write on a doubling feedback loop, both ports on R4.
        ALUOP = 3'b000; OPERAND2 = 8'h07; WRITEREG = 3'd4; WRITEENABLE = 1'b1;
        step();
        ALUOP = 3'b001; READREG1 = 3'd4; READREG2 = 3'd4;
        #1; OPERAND2 = REGOUT2; #1;
        check8("rdw pre-edge regout1", REGOUT1, 8'h07);
        check8("rdw pre-edge regout2", REGOUT2, 8'h07);
        check8("rdw alu 0E", ALU_RESULT, 8'h0E);
        step();
        check8("rdw after 1 edge", REGOUT1, 8'h0E);
        OPERAND2 = REGOUT2; #1;
        step();
        check8("rdw after 2 edges", REGOUT1, 8'h1C);
        check8("rdw port2 after 2 edges", REGOUT2, 8'h1C);

        // Write attempts with WRITEENABLE low.
        WRITEENABLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ALUOP = 3'b000; OPERAND2 = 8'(8'h3C + k); WRITEREG = 3'(k + 3);
            step();
        end
        check_all_regs("we low", 8'h00, 1'b1);
        READREG1 = 3'd4; #1;
        check8("we low R4 kept", REGOUT1, 8'h1C);

        // Random traffic against the model, with occasional reset.
        for (int n = 0; n < 400; n++) begin
            RESET       = ($urandom_range(0, 24) == 0);
            WRITEENABLE = $urandom_range(0, 1);
            WRITEREG    = 3'($urandom_range(0, 7));
            READREG1    = 3'($urandom_range(0, 7));
            READREG2    = 3'($urandom_range(0, 7));
            ALUOP       = 3'($urandom_range(0, 7));
            OPERAND2    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            check_vs_model($sformatf("rand%0d", n));
            step();
        end
        RESET = 1'b0; WRITEENABLE = 1'b0;
        check_all_regs("rand final", 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
